// File: rtl/inv_aes_stream.sv
// Byte-stream front end for a 128-bit inverse-cipher core.
// Packs key and ciphertext bytes MSB-first and hands full blocks to the core.
// Supervises the core handshake with a timeout, then streams the plaintext
// result out one byte per handshake.
module inv_aes_stream #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [7:0]   in_byte_i,
    input  logic         in_is_key_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic         core_start_o,
    output logic [127:0] core_text_o,
    output logic [127:0] core_key_o,
    input  logic         core_busy_i,
    input  logic         core_done_i,
    input  logic [127:0] core_result_i,
    output logic [7:0]   out_byte_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         key_loaded_o,
    output logic         err_nokey_o,
    output logic         err_timeout_o
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_e;

    localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic [127:0]    key_q;
    logic [127:0]    text_q;
    logic [127:0]    out_q;
    logic [3:0]      key_cnt_q;
    logic [3:0]      blk_cnt_q;
    logic [3:0]      out_cnt_q;
    logic [TW-1:0]   tmo_q;
    logic            in_ready_q;
    logic            core_start_q;
    logic            out_valid_q;
    logic            key_loaded_q;
    logic            err_nokey_q;
    logic            err_timeout_q;
    logic            in_fire;

    assign in_fire       = in_valid_i & in_ready_q;

    assign in_ready_o    = in_ready_q;
    assign core_start_o  = core_start_q;
    assign core_text_o   = text_q;
    assign core_key_o    = key_q;
    assign out_byte_o    = out_q[127:120];
    assign out_valid_o   = out_valid_q;
    assign key_loaded_o  = key_loaded_q;
    assign err_nokey_o   = err_nokey_q;
    assign err_timeout_o = err_timeout_q;

    // Control FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            key_q         <= '0;
            text_q        <= '0;
            out_q         <= '0;
            key_cnt_q     <= '0;
            blk_cnt_q     <= '0;
            out_cnt_q     <= '0;
            tmo_q         <= '0;
            in_ready_q    <= 1'b0;
            core_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            key_loaded_q  <= 1'b0;
            err_nokey_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        if (in_is_key_i) begin
                            key_q     <= {key_q[119:0], in_byte_i};
                            key_cnt_q <= key_cnt_q + 4'd1;
                            // Starting a fresh key invalidates any half-collected text block.
                            if (key_cnt_q == 4'd0) begin
                                key_loaded_q <= 1'b0;
                                blk_cnt_q    <= '0;
                            end
                            if (key_cnt_q == 4'd15) begin
                                key_loaded_q <= 1'b1;
                            end
                        end else if (!key_loaded_q) begin
                            err_nokey_q <= 1'b1;
                        end else begin
                            text_q    <= {text_q[119:0], in_byte_i};
                            blk_cnt_q <= blk_cnt_q + 4'd1;
                            if (blk_cnt_q == 4'd15) begin
                                state_q      <= START;
                                in_ready_q   <= 1'b0;
                                core_start_q <= 1'b1;
                                tmo_q        <= '0;
                            end
                        end
                    end
                end

                START: begin
                    if (core_busy_i) begin
                        core_start_q <= 1'b0;
                        tmo_q        <= tmo_q + 1'b1;
                        state_q      <= WAIT;
                    end else if (tmo_q == TMO_LAST) begin
                        err_timeout_q <= 1'b1;
                        core_start_q  <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                WAIT: begin
                    // Busy was already seen high to get here, so a stale done level cannot end the wait early.
                    if (!core_busy_i && core_done_i) begin
                        out_q       <= core_result_i;
                        out_cnt_q   <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DRAIN;
                    end else if (tmo_q == TMO_LAST) begin
                        err_timeout_q <= 1'b1;
                        in_ready_q    <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                DRAIN: begin
                    if (out_ready_i) begin
                        out_q     <= {out_q[119:0], 8'h00};
                        out_cnt_q <= out_cnt_q + 4'd1;
                        if (out_cnt_q == 4'd15) begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_aes_stream.sv
// Self-checking bench for inv_aes_stream.
// A behavioural core model answers start requests; a byte-level reference
// model predicts the plaintext stream and the status flags.
module tb_inv_aes_stream;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk;
    logic         rst_ni;
    logic [7:0]   in_byte_i;
    logic         in_is_key_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         core_start_o;
    logic [127:0] core_text_o;
    logic [127:0] core_key_o;
    logic         core_busy_i;
    logic         core_done_i;
    logic [127:0] core_result_i;
    logic [7:0]   out_byte_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic         key_loaded_o;
    logic         err_nokey_o;
    logic         err_timeout_o;

    int checkCount = 0;
    int errorCount = 0;

    // Bench knobs for the core and sink behaviour.
    bit coreDead    = 1'b0;
    bit doneStuck   = 1'b0;
    bit randLat     = 1'b0;
    int coreLatency = 4;
    bit stallReady  = 1'b0;
    bit rndReady    = 1'b0;

    // Reference model state.
    bit         mKeyLoaded;
    int         mKeyCnt;
    logic [7:0] mKey [16];
    logic [7:0] mText [$];
    bit         mNoKey;
    bit         mTimeout;
    bit         dropNext;
    logic [7:0] expQ [$];
    logic [7:0] gotQ [$];

    inv_aes_stream #(.TIMEOUT_CYC(64)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .in_byte_i     (in_byte_i),
        .in_is_key_i   (in_is_key_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .core_start_o  (core_start_o),
        .core_text_o   (core_text_o),
        .core_key_o    (core_key_o),
        .core_busy_i   (core_busy_i),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i),
        .out_byte_o    (out_byte_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .key_loaded_o  (key_loaded_o),
        .err_nokey_o   (err_nokey_o),
        .err_timeout_o (err_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The known-answer vector decrypts to its published plaintext; other blocks use a keyed scramble.
    function automatic logic [127:0] coreFunc(input logic [127:0] text, input logic [127:0] key);
        if (text == KAT_CT && key == KAT_KEY) return KAT_PT;
        return text ^ {key[63:0], key[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mKeyLoaded = 1'b0;
        mKeyCnt    = 0;
        mText.delete();
        mNoKey     = 1'b0;
        mTimeout   = 1'b0;
        dropNext   = 1'b0;
    endtask

    // Spec-level effect of one accepted byte.
    task automatic modelAccept(input logic [7:0] b, input bit isKey);
        logic [127:0] t;
        logic [127:0] k;
        logic [127:0] r;
        if (isKey) begin
            if (mKeyCnt == 0) begin
                mKeyLoaded = 1'b0;
                mText.delete();
            end
            mKey[mKeyCnt] = b;
            mKeyCnt = (mKeyCnt + 1) % 16;
            if (mKeyCnt == 0) mKeyLoaded = 1'b1;
        end else if (!mKeyLoaded) begin
            mNoKey = 1'b1;
        end else begin
            mText.push_back(b);
            if (mText.size() == 16) begin
                for (int i = 0; i < 16; i++) begin
                    t[127-8*i -: 8] = mText[i];
                    k[127-8*i -: 8] = mKey[i];
                end
                r = coreFunc(t, k);
                if (!dropNext) begin
                    for (int i = 0; i < 16; i++) expQ.push_back(r[127-8*i -: 8]);
                end
                dropNext = 1'b0;
                mText.delete();
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit isKey);
        int waitCyc;
        waitCyc     = 0;
        in_byte_i   = b;
        in_is_key_i = isKey;
        in_valid_i  = 1'b1;
        @(negedge clk);
        while (!in_ready_o && waitCyc < 1000) begin
            @(negedge clk);
            waitCyc++;
        end
        if (waitCyc >= 1000) begin
            checkOutput("in_ready_wait", 128'(in_ready_o), 128'(1));
            in_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        modelAccept(b, isKey);
    endtask

    task automatic sendKey(input logic [127:0] k);
        for (int i = 0; i < 16; i++) applyStimulus(k[127-8*i -: 8], 1'b1);
    endtask

    task automatic sendBlock(input logic [127:0] t);
        for (int i = 0; i < 16; i++) applyStimulus(t[127-8*i -: 8], 1'b0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic waitDrain(input string tag);
        int cyc;
        int n;
        cyc = 0;
        while (gotQ.size() < expQ.size() && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput({tag, "_count"}, 128'(gotQ.size()), 128'(expQ.size()));
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutput({tag, "_byte"}, 128'(gotQ[i]), 128'(expQ[i]));
        gotQ.delete();
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, "_out_valid_idle"}, 128'(out_valid_o), 128'(0));
    endtask

    // Behavioural decryption core: busy for a few cycles, then done with the result.
    initial begin : coreModel
        int lat;
        core_busy_i   = 1'b0;
        core_done_i   = 1'b0;
        core_result_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!doneStuck) core_done_i = 1'b0;
            if (!coreDead && core_start_o) begin
                lat = randLat ? int'($urandom_range(1, 8)) : coreLatency;
                core_busy_i = 1'b1;
                repeat (lat) @(posedge clk);
                #1;
                core_result_i = coreFunc(core_text_o, core_key_o);
                core_busy_i   = 1'b0;
                core_done_i   = 1'b1;
                @(posedge clk);
                #1;
                if (!doneStuck) core_done_i = 1'b0;
            end
        end
    end

    // Sink readiness: always ready, randomly ready, or forced stall.
    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = stallReady ? 1'b0 : (rndReady ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Record every output byte that is about to be handshaken on the next edge.
    always @(negedge clk) begin
        if (rst_ni && out_valid_o && out_ready_i) gotQ.push_back(out_byte_o);
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainFlow
        int cnt;
        int changes;
        logic [7:0] b0;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_byte_i   = 8'h00;
        in_is_key_i = 1'b0;
        modelReset();

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready_o), 128'(0));
        checkOutput("rst_out_valid", 128'(out_valid_o), 128'(0));
        checkOutput("rst_core_start", 128'(core_start_o), 128'(0));
        checkOutput("rst_key_loaded", 128'(key_loaded_o), 128'(0));
        checkOutput("rst_core_text", core_text_o, 128'(0));
        checkOutput("rst_core_key", core_key_o, 128'(0));
        checkOutput("rst_errs", 128'({err_nokey_o, err_timeout_o}), 128'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_rst", 128'(in_ready_o), 128'(1));

        // Known-answer block.
        sendKey(KAT_KEY);
        sendBlock(KAT_CT);
        checkOutput("kat_expected_first", 128'(expQ[0]), 128'(8'h00));
        waitDrain("kat");
        checkOutput("kat_key_loaded", 128'(key_loaded_o), 128'(mKeyLoaded));
        checkOutput("kat_err_nokey", 128'(err_nokey_o), 128'(mNoKey));
        checkOutput("kat_err_timeout", 128'(err_timeout_o), 128'(mTimeout));

        // Back-to-back block with the same key.
        sendBlock(rand128());
        waitDrain("reuse_key");

        // Text before any key.
        @(negedge clk);
        rst_ni = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'hAA, 1'b0);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (core_start_o) cnt++;
        end
        checkOutput("nokey_no_start", 128'(cnt), 128'(0));
        checkOutput("nokey_flag", 128'(err_nokey_o), 128'(mNoKey));
        sendKey(rand128());
        sendBlock(rand128());
        waitDrain("after_nokey");
        checkOutput("nokey_sticky", 128'(err_nokey_o), 128'(mNoKey));

        // Sink stall for 10 cycles in DRAIN.
        stallReady = 1'b1;
        sendBlock(rand128());
        cnt = 0;
        while (!out_valid_o && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("stall_valid_seen", 128'(out_valid_o), 128'(1));
        b0 = out_byte_o;
        changes = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_byte_o !== b0 || out_valid_o !== 1'b1) changes++;
        end
        checkOutput("stall_stable", 128'(changes), 128'(0));
        checkOutput("stall_first_byte", 128'(b0), 128'(expQ[0]));
        stallReady = 1'b0;
        waitDrain("stall");

        // Randomized mix of key reloads, partial blocks and full blocks.
        rndReady = 1'b1;
        randLat  = 1'b1;
        for (int blk = 0; blk < 10; blk++) begin
            case ($urandom_range(0, 3))
                0: sendKey(rand128());
                1: begin
                    for (int i = 0; i < int'($urandom_range(1, 15)); i++) applyStimulus(8'($urandom), 1'b0);
                    sendKey(rand128());
                end
                2: begin
                    logic [127:0] k;
                    k = rand128();
                    for (int i = 0; i < 5; i++) applyStimulus(k[127-8*i -: 8], 1'b1);
                    applyStimulus(8'($urandom), 1'b0);
                    for (int i = 5; i < 16; i++) applyStimulus(k[127-8*i -: 8], 1'b1);
                end
                default: ;
            endcase
            sendBlock(rand128());
        end
        waitDrain("random");
        checkOutput("random_err_nokey", 128'(err_nokey_o), 128'(mNoKey));
        checkOutput("random_key_loaded", 128'(key_loaded_o), 128'(mKeyLoaded));
        rndReady = 1'b0;
        randLat  = 1'b0;

        // Done stuck high across two blocks.
        doneStuck   = 1'b1;
        coreLatency = 6;
        sendBlock(rand128());
        sendBlock(rand128());
        waitDrain("done_stuck");
        doneStuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Core never goes busy: timeout.
        coreDead = 1'b1;
        dropNext = 1'b1;
        sendBlock(rand128());
        cnt = 0;
        while (core_start_o && cnt < 300) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        mTimeout = 1'b1;
        checkOutput("timeout_cycles", 128'(cnt), 128'(64));
        checkOutput("timeout_flag", 128'(err_timeout_o), 128'(mTimeout));
        checkOutput("timeout_in_ready", 128'(in_ready_o), 128'(1));
        checkOutput("timeout_out_valid", 128'(out_valid_o), 128'(0));
        coreDead = 1'b0;
        sendBlock(rand128());
        waitDrain("after_timeout");
        checkOutput("timeout_sticky", 128'(err_timeout_o), 128'(mTimeout));

        // Reset pulse while the core is working.
        coreLatency = 30;
        sendBlock(rand128());
        cnt = 0;
        while (!(core_busy_i && !core_start_o) && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_core_text", core_text_o, 128'(0));
        checkOutput("midrst_core_key", core_key_o, 128'(0));
        checkOutput("midrst_key_loaded", 128'(key_loaded_o), 128'(0));
        checkOutput("midrst_outs", 128'({core_start_o, out_valid_o, in_ready_o}), 128'(0));
        checkOutput("midrst_errs", 128'({err_nokey_o, err_timeout_o}), 128'(0));
        expQ.delete();
        modelReset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_no_output", 128'(gotQ.size()), 128'(0));
        coreLatency = 3;
        sendKey(rand128());
        sendBlock(rand128());
        waitDrain("after_midrst");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/inv_aes_stream.md
INV_AES_STREAM -- requirements
Module: inv_aes_stream

Interface
REQ-001 Parameter: TIMEOUT_CYC, 64, max cycles from core_start assertion to result capture before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rest  in  1  asynchronous, active-low reset.
REQ-004 in_byte  in  8  ciphertext or key byte.
REQ-005 in_is_key  in  1  qualifies in_byte as key byte (1) or ciphertext byte (0).
REQ-006 in_valid / in_ready  in / out  1 / 1  input byte handshake.
REQ-007 core_start  out  1  start request to decryption core.
REQ-008 core_text / core_key  out  128 / 128  ciphertext block and key to the core.
REQ-009 core_busy / core_done / core_result  in  1 / 1 / 128  decryption core status and result.
REQ-010 out_byte / out_valid / out_ready  out / out / in  8 / 1 / 1  plaintext byte handshake.
REQ-011 key_loaded / err_nokey / err_timeout  out  1 / 1 / 1  status; both err flags are sticky.

Function
REQ-012 Bytes are packed MSB-first: first byte of a 16-byte group lands in bits [127:120].
REQ-013 States: IDLE, START, WAIT, DRAIN; transfer occurs only when valid and ready are both 1 in the same cycle.
REQ-014 IDLE: in_ready=1; every other state: in_ready=0.
REQ-015 Key byte accepted with key_cnt==0 clears key_loaded; the 16th key byte sets key_loaded and wraps key_cnt to 0.
REQ-016 A text byte accepted while key_loaded=0 is discarded and sets err_nokey; blk_cnt is unchanged.
REQ-017 A text byte accepted while key_loaded=1 shifts into core_text and increments blk_cnt; a partial text block survives interleaved key bytes only if key_loaded remains 1.
REQ-018 The 16th accepted text byte in cycle T moves IDLE->START at T+1; blk_cnt wraps to 0.
REQ-019 START: core_start=1 and is held until core_busy is sampled 1, then ->WAIT with core_start=0 the next cycle.
REQ-020 WAIT: when core_busy=0 and core_done=1, capture core_result into the output shift register and ->DRAIN.
REQ-021 core_done is treated as level-only, never as a completion edge; the exit condition is busy-low after busy was seen high in this transaction.
REQ-022 core_text and core_key are held constant from entry into START until exit from WAIT.
REQ-023 Timeout counter: cleared on entry to START, increments each cycle in START/WAIT.
REQ-024 On reaching TIMEOUT_CYC, the block sets err_timeout, drops the block, deasserts core_start, and returns to IDLE.
REQ-025 DRAIN: out_valid=1, out_byte = shift register [127:120].
REQ-026 DRAIN: out_byte is held stable while out_ready=0; each handshake shifts left 8 bits.
REQ-027 The 16th output handshake ->IDLE with out_valid=0 in the following cycle.
REQ-028 Minimum latency from 16th text byte to first out_valid: 1 + core latency + 1 cycles.
REQ-029 Key remains loaded across blocks; back-to-back blocks need no key reload.

Reset
REQ-030 rest=0 asynchronously forces IDLE and clears all counters, shift registers, key_loaded, err_nokey, err_timeout, core_start, and out_valid, plus all 128-bit outputs to 0.
REQ-031 While rest=0, in_ready=0; in_ready=1 in the first cycle after release.
REQ-032 Reset mid-transaction (any state) aborts without emitting partial output; the key must be reloaded.

Verification
REQ-033 Key bytes 00..0f, then text 69c4e0d86a7b0430d8cdb78070b4c55a with a compliant core -> out bytes 00 11 22 ... ff in order, key_loaded=1, no errors.
REQ-034 Text byte 0xAA before any key -> err_nokey=1, byte dropped, no core_start; later valid key+block decrypts correctly.
REQ-035 out_ready held 0 for 10 cycles in DRAIN -> out_byte/out_valid stable, no byte lost, then 16 bytes emitted.
REQ-036 core_busy never rises after core_start -> err_timeout=1 after exactly 64 cycles, state IDLE, in_ready=1.
REQ-037 rest pulsed low during WAIT -> all outputs 0 immediately, key_loaded=0; a subsequent key+block completes normally.
REQ-038 Two consecutive blocks with one key load, core_done stuck high from block 1 -> block 2 output captured only after a fresh busy high/low cycle.
